// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package pc_fetch_pkg;

    localparam int unsigned PC_INC           = 4;
    localparam int unsigned INSTR_ALIGN_BITS = 2;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, issues word fetches, buffers one instruction for decode.
// Optional misaligned-redirect trap enabled by defining PC_FETCH_MISALIGN_TRAP_EN.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            if_ready
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign_err
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            kill_q, kill_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_instr_q, if_instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic            req_fire;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] redir_pc;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic            err_q, err_d;
    logic            redirect_bad;
    assign redirect_bad = redirect_valid && (redirect_pc[INSTR_ALIGN_BITS-1:0] != '0);
`else
    logic            unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[INSTR_ALIGN_BITS-1:0];
`endif

    // A request is committed only on the registered valid meeting ready.
    assign req_fire = req_valid_q && imem_req_ready;
    assign pc_inc   = pc_q + XLEN'(PC_INC);
    assign redir_pc = {redirect_pc[XLEN-1:INSTR_ALIGN_BITS], {INSTR_ALIGN_BITS{1'b0}}};

    // Next-state and registered-output logic; redirect takes priority in every state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        kill_d     = kill_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        err_d      = err_q;
`endif

        unique case (state_q)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                    if (req_fire) begin
                        kill_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end else if (req_fire) begin
                    fetch_pc_d = pc_q;
                    pc_d       = pc_inc;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redir_pc;
                    if (imem_rsp_valid) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        if_instr_d = imem_rsp_data;
                        if_pc_d    = fetch_pc_q;
                        if_valid_d = 1'b1;
                        state_d    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_d       = redir_pc;
                    if_valid_d = 1'b0;
                    state_d    = ST_REQ;
                end else if (if_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = ST_REQ;
                end
            end
            default: begin
            end
        endcase

`ifdef PC_FETCH_MISALIGN_TRAP_EN
        // A misaligned target parks the unit until reset.
        if (redirect_bad && (state_q != ST_HALT)) begin
            pc_d       = pc_q;
            kill_d     = 1'b0;
            if_valid_d = 1'b0;
            err_d      = 1'b1;
            state_d    = ST_HALT;
        end
`endif

        req_valid_d = (state_d == ST_REQ);
        req_addr_d  = pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
            kill_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_instr_q  <= '0;
            if_pc_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_pc_q  <= fetch_pc_d;
            kill_q      <= kill_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            if_valid_q  <= if_valid_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
        end
    end

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign misalign_err = err_q;
`endif

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign if_valid       = if_valid_q;
    assign if_instr       = if_instr_q;
    assign if_pc          = if_pc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch with a one-cycle instruction memory model.
module tb_pc_fetch;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int checks = 0;
    int errors = 0;
    int vcycles = 0;

    pc_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready)
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: the memory answers one cycle after each accepted request.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = imem_req_valid & imem_req_ready;
        a   = imem_req_addr;
        @(posedge clk);
        @(negedge clk);
        imem_rsp_valid = acc;
        imem_rsp_data  = acc ? mem_word(a) : 32'h0;
        if (if_valid) vcycles++;
    endtask

    // From REQ with the expected address offered: accept, respond, present.
    task automatic do_fetch(input logic [31:0] a);
        chk("req_valid", 32'(imem_req_valid), 32'd1);
        chk("req_addr", imem_req_addr, a);
        tick();
        tick();
        chk("if_valid", 32'(if_valid), 32'd1);
        chk("if_pc", if_pc, a);
        chk("if_instr", if_instr, mem_word(a));
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if_ready       = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        chk("rst_misalign", 32'(misalign_err), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Streaming fetch: addresses 0,4,8,C, one instruction every three cycles.
        vcycles = 0;
        for (int i = 0; i < 4; i++) begin
            do_fetch(32'(i * 4));
            tick();
        end
        chk("valid_one_in_three", 32'(vcycles), 32'd4);
        chk("stream_next_addr", imem_req_addr, 32'h10);

        // Restart and hold the instruction at pc 4 for five cycles.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_fetch(32'h0);
        tick();
        if_ready = 1'b0;
        do_fetch(32'h4);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 32'(if_valid), 32'd1);
            chk("hold_pc", if_pc, 32'h4);
            chk("hold_instr", if_instr, mem_word(32'h4));
            chk("hold_no_req", 32'(imem_req_valid), 32'd0);
        end
        if_ready = 1'b1;
        tick();
        chk("hold_release_valid", 32'(if_valid), 32'd0);
        chk("hold_next_addr", imem_req_addr, 32'h8);

        // Redirect while the fetch of 0x8 waits; its response must be dropped.
        tick();
        chk("wait_rsp_present", 32'(imem_rsp_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("wait_redir_if_valid", 32'(if_valid), 32'd0);
        do_fetch(32'h100);
        tick();

        // Redirect on an unaccepted request, then squash a held instruction.
        imem_req_ready = 1'b0;
        tick();
        chk("stall_addr", imem_req_addr, 32'h104);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_valid = 1'b0;
        chk("stall_redir_valid", 32'(imem_req_valid), 32'd1);
        chk("stall_redir_addr", imem_req_addr, 32'h10);
        imem_req_ready = 1'b1;
        if_ready       = 1'b0;
        do_fetch(32'h10);
        tick();
        chk("hold10_valid", 32'(if_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        chk("squash_if_valid", 32'(if_valid), 32'd0);
        chk("squash_next_addr", imem_req_addr, 32'h200);

        // PC wrap at the top of the address space.
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        do_fetch(32'hFFFF_FFFC);
        tick();
        chk("wrap_next_addr", imem_req_addr, 32'h0);

        // Asynchronous reset in WAIT clears outputs immediately, then refetch.
        tick();
        chk("pre_rst_wait", 32'(imem_req_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("async_rst_if_valid", 32'(if_valid), 32'd0);
        chk("async_rst_if_pc", if_pc, 32'h0);
        chk("async_rst_if_instr", if_instr, 32'h0);
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_fetch(32'h0);
        tick();

        // Misaligned redirect on an accepted request.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        chk("mis_req_valid0", 32'(imem_req_valid), 32'd0);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        chk("mis_err", 32'(misalign_err), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt_no_req", 32'(imem_req_valid), 32'd0);
            chk("halt_if_valid", 32'(if_valid), 32'd0);
        end
        chk("halt_err_sticky", 32'(misalign_err), 32'd1);
`else
        tick();
        chk("mask_if_valid", 32'(if_valid), 32'd0);
        do_fetch(32'h100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Instruction-fetch front end. Consumes the next-PC redirect produced by the branch/jump select logic and owns the architectural PC register.
- Issues word fetches to instruction memory over a valid/ready request port and collects responses.
- Presents each fetched instruction, with its PC, to decode through a one-entry valid/ready output buffer.
- Redirects squash in-flight and buffered fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
- XLEN, 32, PC and instruction width.

Ports:
- clk  input  1  system clock; one clock.
- rst_n  input  1  reset, asynchronous and active-low.
- redirect_valid  input  1  next PC is a taken branch/jump target this cycle.
- redirect_pc  input  XLEN  target PC from branch/jump select logic.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  XLEN  fetch word address.
- imem_req_ready  input  1  memory accepts request.
- imem_rsp_valid  input  1  response data valid; exactly one per accepted request, in order.
- imem_rsp_data  input  XLEN  fetched instruction word.
- if_valid  output  1  instruction available to decode.
- if_instr  output  XLEN  instruction word.
- if_pc  output  XLEN  PC of if_instr.
- if_ready  input  1  decode accepts instruction.

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC, state=REQ, kill=0, if_valid=0, if_instr=0, if_pc=0, imem_req_valid=0. imem_req_valid first rises in the first clk edge after rst_n deasserts.
- Reset mid-operation discards any outstanding request. The memory side is reset by the same rst_n.
- State REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - On req_ready: fetch_pc<=pc, pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), go WAIT.
- State WAIT:
  - imem_req_valid=0.
  - On rsp_valid with kill=0: if_instr<=rsp_data, if_pc<=fetch_pc, if_valid<=1, go HOLD.
  - On rsp_valid with kill=1: drop the data, kill<=0, go REQ.
- State HOLD:
  - if_valid=1. if_instr and if_pc are stable while if_ready=0.
  - On if_ready: if_valid<=0, go REQ.
- Redirect has priority over all other events in the same cycle:
  - REQ, req_ready=0: pc<=redirect_pc. The unaccepted request address may change; a request is committed only on valid&ready.
  - REQ, req_ready=1: the accepted request is stale. pc<=redirect_pc (no +4), kill<=1, go WAIT.
  - WAIT: pc<=redirect_pc, kill<=1. A response arriving in the same cycle is dropped and the unit goes to REQ with kill<=0.
  - HOLD: if_valid<=0 (squash, regardless of if_ready), pc<=redirect_pc, go REQ.
- redirect_pc[1:0] is forced to 2'b00 unless the optional feature is enabled.
- Throughput: at most one instruction per 3 cycles with single-cycle memory (REQ, WAIT, HOLD).
- Latency: 1 cycle from rsp_valid to if_valid.

Optional Feature:
- Macro: PC_FETCH_MISALIGN_TRAP_EN.
- When defined:
  - Adds output misalign_err (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets misalign_err sticky and enters state HALT.
  - HALT: no requests, if_valid=0; any outstanding response is dropped.
  - Only reset exits HALT.
- When not defined: no port, no HALT state; low two bits are silently masked.

Decomposition:
- pc_fetch_pkg holds:
  - state enum (REQ, WAIT, HOLD, HALT);
  - constants PC_INC=4 and INSTR_ALIGN_BITS=2;
  - default RESET_PC.
- No sub-module. The incrementer and output buffer are inline; the existing 2:1 mux primitive may be reused for redirect selection.

Test Plan:
- Reset release, RESET_PC=0, memory always ready, 1-cycle response, if_ready=1 -> req addrs 0,4,8,C; if_pc matches each; if_valid one cycle in every three.
- if_ready=0 for 5 cycles while holding the instr at pc 4 -> if_instr/if_pc stable, no new request; then if_ready=1 -> next req addr 8.
- Redirect to 32'h100 in the same cycle an accepted req to 0x8 is in WAIT -> response for 0x8 dropped, never presented; next req addr 0x100; if_pc=0x100.
- Redirect to 0x200 while HOLD holds the instr at 0x10 with if_ready=0 -> if_valid drops next cycle; next req addr 0x200.
- PC=32'hFFFF_FFFC fetch accepted -> next req addr 0. rst_n pulsed low during WAIT -> outputs zero immediately; refetch from RESET_PC.
- With PC_FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> misalign_err=1 and no further requests. Without the macro -> next req addr 0x100.
